// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave register bank: parametrised register count and width, byte strobes,
// read-only hardware-fed registers, per-register write pulses and SLVERR decode.
module axi4l_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, w_held_q;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic [1:0]            bresp_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  commit, w_ok;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_data;
  logic [1:0]            rresp_q;
  logic                  rd_hit;
  logic [IDX_W-1:0]      ar_idx;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_d = w_state_q;
    commit    = 1'b0;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    BVALID    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        // Readies stay low for the whole time ARESETN is asserted, not only after its edge.
        AWREADY = ARESETN && !aw_held_q;
        WREADY  = ARESETN && !w_held_q;
        if (aw_held_q && w_held_q) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Writable, in-range target: anything else is answered with SLVERR.
  always_comb begin
    w_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (aw_idx_q == IDX_W'(i)) w_ok = !RO_MASK[i];
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      // NOTE: the bank is built from flops, not RAM, so every entry is reset explicitly.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
    end else begin
      w_state_q  <= w_state_d;
      wr_pulse_q <= '0;
      if (AWVALID && AWREADY) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= AWADDR[ADDR_WIDTH-1:LSB];
      end
      if (WVALID && WREADY) begin
        w_held_q <= 1'b1;
        wdata_q  <= WDATA;
        wstrb_q  <= WSTRB;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_ok && aw_idx_q == IDX_W'(i)) begin
            wr_pulse_q[i] <= 1'b1;
            for (int b = 0; b < STRB_W; b++)
              if (wstrb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end
    end
  end

  assign ar_idx = ARADDR[ADDR_WIDTH-1:LSB];

  // Read-only slots return the live hardware input sampled on the AR handshake.
  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_hit  = 1'b1;
        rd_data = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  assign ARREADY = ARESETN && !rvalid_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ARVALID && ARREADY) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
    end else if (RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // Protection bits, sub-word address bits and unused hw_in slices are intentionally ignored.
  logic unused_inputs;
  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[LSB-1:0], ARADDR[LSB-1:0], hw_in};

endmodule

// File: tb/tb_axi4l_regbank.sv
// Scoreboard bench for axi4l_regbank: directed scenarios plus randomized traffic
// checked against an array-based register model.
module tb_axi4l_regbank;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NR = 16;
  localparam logic [NR-1:0] RO  = 16'h0020;
  localparam logic [DW-1:0] RST = 32'h5A5A_0F0F;

  logic          clk = 1'b0;
  logic          ARESETN;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0]    WSTRB;
  logic [1:0]    BRESP, RRESP;
  logic [NR*DW-1:0] reg_out, hw_in;
  logic [NR-1:0] wr_pulse;

  typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rexp_t;

  logic [1:0]    bexp[$];
  rexp_t         rexp[$];
  int            pexp[$];
  logic [DW-1:0] model [NR];
  int            checks = 0;
  int            failures = 0;
  int            rdy_mode = 0;  // 0: ready high, 1: random, 2: BREADY held low

  always #5 clk = ~clk;

  axi4l_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO), .RST_VAL(RST)) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .hw_in(hw_in), .wr_pulse(wr_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation whenever the DUT completes a response.
  always @(negedge clk) begin
    if (ARESETN && BVALID && BREADY) begin
      if (bexp.size() == 0) check("bresp_unexpected", 64'(BVALID), 64'(0));
      else check("bresp", 64'(BRESP), 64'(bexp.pop_front()));
    end
  end

  always @(negedge clk) begin
    rexp_t e;
    if (ARESETN && RVALID && RREADY) begin
      if (rexp.size() == 0) check("rvalid_unexpected", 64'(RVALID), 64'(0));
      else begin
        e = rexp.pop_front();
        check("rdata", 64'(RDATA), 64'(e.data));
        check("rresp", 64'(RRESP), 64'(e.resp));
      end
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] want;
    if (ARESETN && wr_pulse != '0) begin
      if (pexp.size() == 0) check("wr_pulse_unexpected", 64'(wr_pulse), 64'(0));
      else begin
        want = '0;
        want[pexp.pop_front()] = 1'b1;
        check("wr_pulse", 64'(wr_pulse), 64'(want));
      end
    end
  end

  initial begin
    BREADY = 1'b1;
    RREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       begin BREADY = 1'($urandom_range(0, 1)); RREADY = 1'($urandom_range(0, 1)); end
        2:       begin BREADY = 1'b0; RREADY = 1'b1; end
        default: begin BREADY = 1'b1; RREADY = 1'b1; end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) model[i] = RST;
  endfunction

  // Reference behaviour: index from the word address; out of range or read-only -> SLVERR.
  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    int idx = int'(a) / 4;
    if (idx < NR && !RO[idx]) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      bexp.push_back(2'b00);
      pexp.push_back(idx);
    end else begin
      bexp.push_back(2'b10);
    end
  endfunction

  function automatic rexp_t model_read(input logic [AW-1:0] a);
    int idx = int'(a) / 4;
    rexp_t e;
    if (idx >= NR)   begin e.data = '0;                  e.resp = 2'b10; end
    else if (RO[idx]) begin e.data = hw_in[idx*DW +: DW]; e.resp = 2'b00; end
    else             begin e.data = model[idx];          e.resp = 2'b00; end
    return e;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    logic aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    model_write(a, d, s);
    for (int n = 0; n < 64 && (aw_pend || w_pend); n++) begin
      if (n == aw_dly) begin AWADDR = a; AWVALID = 1'b1; end
      if (n == w_dly)  begin WDATA = d; WSTRB = s; WVALID = 1'b1; end
      @(negedge clk);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge clk); #1;
      if (aw_hs) begin AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin WVALID = 1'b0;  w_pend = 1'b0;  end
    end
    if (aw_pend || w_pend) check("write_handshake_timeout", 64'({aw_pend, w_pend}), 64'(0));
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a);
    logic pend = 1'b1, hs;
    rexp.push_back(model_read(a));
    ARADDR  = a;
    ARVALID = 1'b1;
    for (int n = 0; n < 64 && pend; n++) begin
      @(negedge clk);
      hs = ARVALID && ARREADY;
      @(posedge clk); #1;
      if (hs) begin ARVALID = 1'b0; pend = 1'b0; end
    end
    if (pend) check("read_handshake_timeout", 64'(pend), 64'(0));
    ARVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bexp.size() + rexp.size() + pexp.size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) begin
      check("drain_timeout", 64'(bexp.size() + rexp.size() + pexp.size()), 64'(0));
      bexp.delete(); rexp.delete(); pexp.delete();
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++)
      if (!RO[i]) check($sformatf("%s reg_out[%0d]", tag, i), 64'(reg_out[i*DW +: DW]), 64'(model[i]));
  endtask

  initial begin
    rexp_t hz;
    logic [AW-1:0] a;
    ARESETN = 1'b0;
    AWADDR = '0; AWPROT = 3'b010; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARPROT = 3'b001; ARVALID = 1'b0;
    for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = $urandom;
    hw_in[5*DW +: DW] = 32'hCAFE_0005;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst AWREADY", 64'(AWREADY), 64'(0));
    check("rst WREADY", 64'(WREADY), 64'(0));
    check("rst ARREADY", 64'(ARREADY), 64'(0));
    check("rst BVALID", 64'(BVALID), 64'(0));
    check("rst RVALID", 64'(RVALID), 64'(0));
    check("rst RDATA", 64'(RDATA), 64'(0));
    check("rst resp", 64'({BRESP, RRESP}), 64'(0));
    check("rst wr_pulse", 64'(wr_pulse), 64'(0));
    check_regs("rst");
    @(posedge clk); #1;
    ARESETN = 1'b1;
    @(posedge clk); #1;

    // Basic write then read-back of four registers
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i * 4), DW'(i + 1), 4'hF, 0, 0);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i * 4));
      wait_idle();
    end

    // Byte strobes
    axi_write(7'h00, 32'h1122_3344, 4'hF, 0, 0); wait_idle();
    axi_write(7'h00, 32'hAABB_CCDD, 4'b0101, 0, 0); wait_idle();
    axi_read(7'h00); wait_idle();
    axi_write(7'h00, 32'hFFFF_FFFF, 4'b0000, 0, 0); wait_idle();
    axi_read(7'h03); wait_idle();

    // Out of range index 16
    axi_write(7'h40, 32'hDEAD_0040, 4'hF, 0, 0); wait_idle();
    axi_read(7'h40); wait_idle();
    axi_read(7'h7C); wait_idle();
    check_regs("oor");

    // Read-only register 5
    axi_write(7'h14, 32'h1234_5678, 4'hF, 0, 0); wait_idle();
    axi_read(7'h14); wait_idle();
    check_regs("ro");

    // Read handshaking on the commit cycle of a write to the same register sees the old value
    hz = model_read(7'h04);
    rexp.push_back(hz);
    model_write(7'h04, 32'hDEAD_BEEF, 4'hF);
    AWADDR = 7'h04; AWVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge clk); #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARADDR = 7'h04; ARVALID = 1'b1;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    wait_idle();
    axi_read(7'h04); wait_idle();

    // W three cycles ahead of AW, BREADY stalled for four cycles
    rdy_mode = 2;
    axi_write(7'h1C, 32'h0BAD_F00D, 4'hF, 3, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall BVALID", 64'(BVALID), 64'(1));
      check("stall readies", 64'({AWREADY, WREADY}), 64'(0));
      @(posedge clk); #1;
    end
    rdy_mode = 0;
    wait_idle();
    check_regs("stall");

    // Randomized traffic with random ready backpressure
    rdy_mode = 1;
    for (int k = 0; k < 80; k++) begin
      a = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 127));
      if ($urandom_range(0, 1) != 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a);
      wait_idle();
      if (k % 16 == 0) hw_in[5*DW +: DW] = $urandom;
    end
    rdy_mode = 0;
    @(posedge clk); #1;
    check_regs("rand");

    // Reset with AW captured but W still outstanding
    AWADDR = 7'h08; AWVALID = 1'b1;
    @(negedge clk);
    check("pre-reset AWREADY", 64'(AWREADY), 64'(1));
    @(posedge clk); #1;
    AWVALID = 1'b0;
    ARESETN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ARESETN = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post-reset BVALID", 64'(BVALID), 64'(0));
      check("post-reset wr_pulse", 64'(wr_pulse), 64'(0));
      @(posedge clk); #1;
    end
    check_regs("post-reset");
    axi_write(7'h0C, 32'h0000_C0DE, 4'hF, 4, 0); wait_idle();
    axi_read(7'h0C); wait_idle();
    axi_read(7'h08); wait_idle();

    check("queues empty", 64'(bexp.size() + rexp.size() + pexp.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
